// File: rtl/nvdla_csb_seq_pkg.sv
// Shared types for the CSB command sequencer: command record and sequencer states.
// Build option NVDLA_CSB_SEQ_TIMEOUT_EN enables the watchdog and the ERROR path.
package nvdla_csb_seq_pkg;

  localparam int CSB_ADDR_W = 32;
  localparam int CSB_DATA_W = 32;

  typedef struct packed {
    logic [CSB_ADDR_W-1:0] addr;
    logic [CSB_DATA_W-1:0] wdat;
    logic                  write;
    logic                  wait_intr;
  } csb_cmd_t;

  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT_CPL, WAIT_INTR, POP, DRAIN, ERROR
  } csb_seq_state_t;

  // Wait-for-interrupt wins over write, so the stored write bit is already resolved.
  function automatic csb_cmd_t make_cmd(input logic [CSB_ADDR_W-1:0] addr,
                                        input logic [CSB_DATA_W-1:0] wdat,
                                        input logic write,
                                        input logic wait_intr);
    csb_cmd_t c;
    c.addr      = addr;
    c.wdat      = wdat;
    c.write     = write & ~wait_intr;
    c.wait_intr = wait_intr;
    return c;
  endfunction

endpackage

// File: rtl/nvdla_csb_seq_cmd_fifo.sv
// DEPTH-entry command FIFO for the CSB sequencer; flush has priority over push/pop.
module nvdla_csb_cmd_fifo
  import nvdla_csb_seq_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  csb_cmd_t               data_in,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output csb_cmd_t               head
);

  localparam int AW = $clog2(DEPTH);

  csb_cmd_t     mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         push_ok;
  logic         pop_ok;

  assign count   = wr_ptr - rd_ptr;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push & ~full & ~flush;
  assign pop_ok  = pop & ~empty & ~flush;
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= data_in;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/nvdla_csb_seq.sv
// CSB command sequencer: runs queued write/read/wait-intr commands after one start.
// Define NVDLA_CSB_SEQ_TIMEOUT_EN to build in the watchdog timeout and ERROR state.
module nvdla_csb_seq
  import nvdla_csb_seq_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int TIMEOUT_W = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clear_i,
  input  logic                   cmd_valid_i,
  output logic                   cmd_ready_o,
  input  logic [ADDR_W-1:0]      cmd_addr_i,
  input  logic [DATA_W-1:0]      cmd_wdat_i,
  input  logic                   cmd_write_i,
  input  logic                   cmd_wait_intr_i,
  input  logic                   start_i,
  input  logic [TIMEOUT_W-1:0]   timeout_cyc_i,
  output logic                   eng_start_o,
  output logic                   eng_clear_o,
  output logic                   eng_enable_o,
  output logic [ADDR_W-1:0]      eng_addr_o,
  output logic [DATA_W-1:0]      eng_wdat_o,
  output logic                   eng_write_o,
  output logic                   eng_wait_intr_o,
  input  logic                   eng_wr_complete_i,
  input  logic                   eng_rd_valid_i,
  input  logic                   eng_intr_i,
  output logic                   sink_req_start_o,
  input  logic                   sink_ready_start_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   evt_o,
  output logic                   err_o,
  output logic [$clog2(DEPTH):0] cmd_cnt_o
);

  localparam int CW = $clog2(DEPTH) + 1;

  csb_seq_state_t state_q, state_d;
  csb_cmd_t       cmd_in, head;
  logic           fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
  logic [CW-1:0]  fifo_count;
  logic [CW-1:0]  cnt_q;
  logic           evt_q, evt_d, done_q, done_d, cnt_inc, start_ack;

  assign cmd_in = make_cmd(CSB_ADDR_W'(cmd_addr_i), CSB_DATA_W'(cmd_wdat_i),
                           cmd_write_i, cmd_wait_intr_i);
  assign fifo_push = cmd_valid_i & ~fifo_full;

  nvdla_csb_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .flush   (fifo_flush),
    .data_in (cmd_in),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count),
    .head    (head)
  );

  // Engine fields are zeroed while nothing is queued so stale entries never leak out.
  assign cmd_ready_o     = ~fifo_full;
  assign eng_addr_o      = fifo_empty ? '0 : ADDR_W'(head.addr);
  assign eng_wdat_o      = fifo_empty ? '0 : DATA_W'(head.wdat);
  assign eng_write_o     = ~fifo_empty & head.write;
  assign eng_wait_intr_o = ~fifo_empty & head.wait_intr;
  assign eng_clear_o     = (state_q == IDLE);
  assign eng_enable_o    = (state_q == ISSUE) || (state_q == WAIT_CPL) || (state_q == WAIT_INTR);
  assign busy_o          = (state_q != IDLE);
  assign evt_o           = evt_q;
  assign done_o          = done_q;
  assign cmd_cnt_o       = cnt_q;

`ifdef NVDLA_CSB_SEQ_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] tmr_q;
  logic                 timeout_hit, err_q, err_set;
  assign timeout_hit = (timeout_cyc_i != '0) && (tmr_q == timeout_cyc_i);
  assign err_o       = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^timeout_cyc_i;
  assign err_o          = 1'b0;
`endif

  always_comb begin
    state_d          = state_q;
    eng_start_o      = 1'b0;
    sink_req_start_o = 1'b0;
    fifo_pop         = 1'b0;
    fifo_flush       = 1'b0;
    evt_d            = 1'b0;
    done_d           = 1'b0;
    cnt_inc          = 1'b0;
    start_ack        = 1'b0;
`ifdef NVDLA_CSB_SEQ_TIMEOUT_EN
    err_set          = 1'b0;
`endif
    case (state_q)
      IDLE: if (start_i) begin
        start_ack = 1'b1;
        if (fifo_empty) done_d  = 1'b1;
        else            state_d = ISSUE;
      end
      ISSUE: begin
        if (head.wait_intr) begin
          eng_start_o = 1'b1;
          state_d     = WAIT_INTR;
        end else if (head.write) begin
          eng_start_o = 1'b1;
          state_d     = WAIT_CPL;
        end else if (sink_ready_start_i) begin
          eng_start_o      = 1'b1;
          sink_req_start_o = 1'b1;
          state_d          = WAIT_CPL;
        end
      end
      WAIT_CPL: if (head.write ? eng_wr_complete_i : eng_rd_valid_i) begin
        evt_d   = 1'b1;
        state_d = POP;
      end
      WAIT_INTR: if (eng_intr_i) begin
        evt_d   = 1'b1;
        state_d = POP;
      end
      POP: begin
        fifo_pop = 1'b1;
        cnt_inc  = 1'b1;
        // A push landing in this cycle still counts as remaining work.
        state_d  = ((fifo_count > CW'(1)) || fifo_push) ? ISSUE : DRAIN;
      end
      DRAIN: if (sink_ready_start_i) begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
`ifdef NVDLA_CSB_SEQ_TIMEOUT_EN
      ERROR: begin
        fifo_flush = 1'b1;
        err_set    = 1'b1;
        done_d     = 1'b1;
        state_d    = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
`ifdef NVDLA_CSB_SEQ_TIMEOUT_EN
    if (timeout_hit && (state_d == state_q) &&
        ((state_q == WAIT_CPL) || (state_q == WAIT_INTR) || (state_q == DRAIN)))
      state_d = ERROR;
`endif
    if (clear_i) begin
      state_d    = IDLE;
      fifo_flush = 1'b1;
      fifo_pop   = 1'b0;
      evt_d      = 1'b0;
      done_d     = 1'b0;
`ifdef NVDLA_CSB_SEQ_TIMEOUT_EN
      err_set    = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      evt_q   <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      evt_q   <= evt_d;
      done_q  <= done_d;
      if (clear_i || start_ack) cnt_q <= '0;
      else if (cnt_inc)         cnt_q <= cnt_q + CW'(1);
    end
  end

`ifdef NVDLA_CSB_SEQ_TIMEOUT_EN
  // The watchdog restarts on every state change and only runs in the waiting states.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tmr_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (state_d != state_q) tmr_q <= '0;
      else if ((state_q == WAIT_CPL) || (state_q == WAIT_INTR) || (state_q == DRAIN))
        tmr_q <= tmr_q + TIMEOUT_W'(1);
      if (clear_i || start_ack) err_q <= 1'b0;
      else if (err_set)         err_q <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_nvdla_csb_seq.sv
// Self-checking bench for nvdla_csb_seq: queue-based reference model plus directed scenarios.
// Timeout scenario runs only when NVDLA_CSB_SEQ_TIMEOUT_EN is defined.
module tb_nvdla_csb_seq;

  localparam int DEPTH = 8;
  localparam int CW    = 4;

  logic        clk = 1'b0, rst_n = 1'b0, clear = 1'b0;
  logic        cmd_valid = 1'b0, cmd_write = 1'b0, cmd_wait = 1'b0, start = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdat = '0;
  logic [15:0] tmo = '0;
  logic        wr_cpl = 1'b0, rd_valid = 1'b0, intr = 1'b0, sink_ready = 1'b1;

  logic          cmd_ready, eng_start, eng_clear, eng_enable, eng_write, eng_wait;
  logic [31:0]   eng_addr, eng_wdat;
  logic          sink_req, busy, done, evt, err;
  logic [CW-1:0] cmd_cnt;

  nvdla_csb_seq #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32), .TIMEOUT_W(16)) dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_addr_i(cmd_addr),
    .cmd_wdat_i(cmd_wdat), .cmd_write_i(cmd_write), .cmd_wait_intr_i(cmd_wait),
    .start_i(start), .timeout_cyc_i(tmo),
    .eng_start_o(eng_start), .eng_clear_o(eng_clear), .eng_enable_o(eng_enable),
    .eng_addr_o(eng_addr), .eng_wdat_o(eng_wdat), .eng_write_o(eng_write),
    .eng_wait_intr_o(eng_wait), .eng_wr_complete_i(wr_cpl), .eng_rd_valid_i(rd_valid),
    .eng_intr_i(intr), .sink_req_start_o(sink_req), .sink_ready_start_i(sink_ready),
    .busy_o(busy), .done_o(done), .evt_o(evt), .err_o(err), .cmd_cnt_o(cmd_cnt)
  );

  always #5 clk = ~clk;

  int nChecks = 0, nFail = 0, evtSeen = 0, doneSeen = 0;
  bit checking = 1'b0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a command queue and a coarse activity phase, advanced once per clock.
  typedef struct { logic [31:0] addr; logic [31:0] wdat; logic write; logic wint; } mcmd_t;
  typedef enum int { M_IDLE, M_ISSUE, M_WCPL, M_WINT, M_POP, M_DRAIN, M_ERR } mphase_t;
  mcmd_t   mq[$];
  mphase_t phase = M_IDLE;
  int      mCnt = 0, mTmr = 0;
  bit      mEvt = 0, mDone = 0, mErr = 0;

  always @(posedge clk or negedge rst_n) begin
    mcmd_t   nc;
    mphase_t nxt;
    bit      pushOk, flushNow, waiting;
    if (!rst_n || clear) begin
      mq.delete(); phase = M_IDLE; mCnt = 0; mTmr = 0; mEvt = 0; mDone = 0; mErr = 0;
    end else begin
      pushOk   = cmd_valid && (mq.size() < DEPTH);
      nc       = '{cmd_addr, cmd_wdat, cmd_write && !cmd_wait, cmd_wait};
      nxt      = phase; mEvt = 0; mDone = 0; flushNow = 0;
      waiting  = (phase == M_WCPL) || (phase == M_WINT) || (phase == M_DRAIN);
      case (phase)
        M_IDLE:  if (start) begin
                   mErr = 0; mCnt = 0;
                   if (mq.size() > 0) nxt = M_ISSUE; else mDone = 1;
                 end
        M_ISSUE: if (mq[0].wint) nxt = M_WINT;
                 else if (mq[0].write || sink_ready) nxt = M_WCPL;
        M_WCPL:  if (mq[0].write ? wr_cpl : rd_valid) begin nxt = M_POP; mEvt = 1; end
        M_WINT:  if (intr) begin nxt = M_POP; mEvt = 1; end
        M_POP:   begin
                   void'(mq.pop_front()); mCnt++;
                   nxt = (mq.size() > 0 || pushOk) ? M_ISSUE : M_DRAIN;
                 end
        M_DRAIN: if (sink_ready) begin nxt = M_IDLE; mDone = 1; end
        default: begin flushNow = 1; mErr = 1; mDone = 1; nxt = M_IDLE; end
      endcase
`ifdef NVDLA_CSB_SEQ_TIMEOUT_EN
      if (waiting && nxt == phase && tmo != 0 && mTmr == int'(tmo)) nxt = M_ERR;
`endif
      if (nxt != phase) mTmr = 0; else if (waiting) mTmr++;
      if (flushNow) mq.delete(); else if (pushOk) mq.push_back(nc);
      phase = nxt;
    end
  end

  // Compare process: every output against the model on each falling edge.
  always @(negedge clk) begin
    mcmd_t h;
    bit    issuing;
    if (rst_n && checking) begin
      h = '{32'h0, 32'h0, 1'b0, 1'b0};
      if (mq.size() > 0) h = mq[0];
      issuing = (phase == M_ISSUE) && (mq.size() > 0);
      checkOutput("cmd_ready",  64'(cmd_ready),  64'(mq.size() < DEPTH));
      checkOutput("busy",       64'(busy),       64'(phase != M_IDLE));
      checkOutput("eng_start",  64'(eng_start),  64'(issuing && (h.wint || h.write || sink_ready)));
      checkOutput("sink_req",   64'(sink_req),   64'(issuing && !h.wint && !h.write && sink_ready));
      checkOutput("eng_clear",  64'(eng_clear),  64'(phase == M_IDLE));
      checkOutput("eng_enable", 64'(eng_enable), 64'(phase == M_ISSUE || phase == M_WCPL || phase == M_WINT));
      checkOutput("eng_addr",   64'(eng_addr),   64'(h.addr));
      checkOutput("eng_wdat",   64'(eng_wdat),   64'(h.wdat));
      checkOutput("eng_write",  64'(eng_write),  64'(h.write));
      checkOutput("eng_wait",   64'(eng_wait),   64'(h.wint));
      checkOutput("evt",        64'(evt),        64'(mEvt));
      checkOutput("done",       64'(done),       64'(mDone));
      checkOutput("err",        64'(err),        64'(mErr));
      checkOutput("cmd_cnt",    64'(cmd_cnt),    64'(mCnt));
    end
  end

  always @(negedge clk) if (rst_n) begin
    if (evt === 1'b1)  evtSeen++;
    if (done === 1'b1) doneSeen++;
  end

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d, input logic w, input logic wi);
    cmd_valid = 1'b1; cmd_addr = a; cmd_wdat = d; cmd_write = w; cmd_wait = wi;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic pulseStart();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic waitEngStart(input string tag);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (eng_start === 1'b1) return;
    end
    checkOutput({tag, "_eng_start_seen"}, 64'd0, 64'd1);
  endtask

  task automatic waitDone(input string tag);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done === 1'b1) return;
    end
    checkOutput({tag, "_done_seen"}, 64'd0, 64'd1);
  endtask

  task automatic completeWrite();
    step(); step(); wr_cpl = 1'b1; step(); wr_cpl = 1'b0;
  endtask

  initial begin
    int e0, d0;
    repeat (3) @(negedge clk);
    checkOutput("rst_busy",  64'(busy),      64'd0);
    checkOutput("rst_ready", 64'(cmd_ready), 64'd1);
    checkOutput("rst_cnt",   64'(cmd_cnt),   64'd0);
    checkOutput("rst_done",  64'(done),      64'd0);
    checkOutput("rst_evt",   64'(evt),       64'd0);
    checkOutput("rst_err",   64'(err),       64'd0);
    checkOutput("rst_start", 64'(eng_start), 64'd0);
    @(posedge clk); #2; rst_n = 1'b1; checking = 1'b1;
    step();

    $display("[TB] three writes");
    e0 = evtSeen; d0 = doneSeen;
    for (int i = 0; i < 3; i++) applyStimulus(32'h10 + 32'(4*i), 32'hA0 + 32'(i), 1'b1, 1'b0);
    pulseStart();
    for (int k = 0; k < 3; k++) begin
      waitEngStart("wr");
      if (k == 0) checkOutput("wr_first_addr", 64'(eng_addr), 64'h10);
      completeWrite();
    end
    waitDone("wr");
    @(negedge clk);
    checkOutput("wr_evt_count",  64'(evtSeen - e0),  64'd3);
    checkOutput("wr_done_count", 64'(doneSeen - d0), 64'd1);
    checkOutput("wr_cnt",        64'(cmd_cnt),       64'd3);
    checkOutput("wr_ready",      64'(cmd_ready),     64'd1);

    $display("[TB] read with stalled sink");
    sink_ready = 1'b0; step();
    applyStimulus(32'h20, 32'h0, 1'b0, 1'b0);
    pulseStart();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("rd_stall_start", 64'(eng_start), 64'd0);
      checkOutput("rd_stall_sreq",  64'(sink_req),  64'd0);
      step();
    end
    sink_ready = 1'b1;
    @(negedge clk);
    checkOutput("rd_start", 64'(eng_start), 64'd1);
    checkOutput("rd_sreq",  64'(sink_req),  64'd1);
    step(); sink_ready = 1'b0;
    step(); rd_valid = 1'b1;
    step(); rd_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); checkOutput("rd_drain_done", 64'(done), 64'd0); step();
    end
    sink_ready = 1'b1;
    waitDone("rd");
    checkOutput("rd_cnt", 64'(cmd_cnt), 64'd1);

    $display("[TB] wait for interrupt");
    applyStimulus(32'h30, 32'h5, 1'b1, 1'b1);
    e0 = evtSeen;
    pulseStart();
    waitEngStart("wi");
    checkOutput("wi_write", 64'(eng_write), 64'd0);
    checkOutput("wi_wait",  64'(eng_wait),  64'd1);
    repeat (20) step();
    checkOutput("wi_busy",    64'(busy),          64'd1);
    checkOutput("wi_no_evt",  64'(evtSeen - e0),  64'd0);
    intr = 1'b1; step(); intr = 1'b0;
    @(negedge clk);
    checkOutput("wi_evt", 64'(evt), 64'd1);
    waitDone("wi");

    $display("[TB] full FIFO");
    e0 = evtSeen;
    for (int i = 0; i < DEPTH; i++) applyStimulus(32'h100 + 32'(4*i), 32'(i), 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("full_ready", 64'(cmd_ready), 64'd0);
    step();
    applyStimulus(32'hBAD, 32'hBAD, 1'b1, 1'b0);
    pulseStart();
    for (int k = 0; k < DEPTH; k++) begin
      waitEngStart("full");
      if (k == 1) checkOutput("full_ready_after_pop", 64'(cmd_ready), 64'd1);
      completeWrite();
      if (k == 0) begin
        @(negedge clk);
        checkOutput("full_pop_evt",   64'(evt),       64'd1);
        checkOutput("full_pop_ready", 64'(cmd_ready), 64'd0);
      end
    end
    waitDone("full");
    checkOutput("full_evt_count", 64'(evtSeen - e0), 64'(DEPTH));
    checkOutput("full_cnt",       64'(cmd_cnt),      64'(DEPTH));

    $display("[TB] clear during wait");
    step();
    applyStimulus(32'h40, 32'h1, 1'b1, 1'b0);
    e0 = evtSeen; d0 = doneSeen;
    pulseStart();
    waitEngStart("clr");
    step(); clear = 1'b1; step(); clear = 1'b0;
    @(negedge clk);
    checkOutput("clr_busy",      64'(busy),      64'd0);
    checkOutput("clr_eng_clear", 64'(eng_clear), 64'd1);
    checkOutput("clr_ready",     64'(cmd_ready), 64'd1);
    repeat (3) step();
    checkOutput("clr_no_evt",  64'(evtSeen - e0),  64'd0);
    checkOutput("clr_no_done", 64'(doneSeen - d0), 64'd0);

    $display("[TB] start on empty queue");
    pulseStart();
    @(negedge clk);
    checkOutput("empty_done", 64'(done), 64'd1);
    checkOutput("empty_busy", 64'(busy), 64'd0);

`ifdef NVDLA_CSB_SEQ_TIMEOUT_EN
    $display("[TB] watchdog timeout");
    step(); tmo = 16'd4;
    applyStimulus(32'h50, 32'h2, 1'b1, 1'b0);
    pulseStart();
    waitDone("tmo");
    checkOutput("tmo_err",   64'(err),       64'd1);
    checkOutput("tmo_cnt",   64'(cmd_cnt),   64'd0);
    checkOutput("tmo_ready", 64'(cmd_ready), 64'd1);
    checkOutput("tmo_busy",  64'(busy),      64'd0);
    step(); tmo = 16'd0;
    pulseStart();
    @(negedge clk);
    checkOutput("tmo_err_cleared", 64'(err), 64'd0);
`endif

    repeat (3) step();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] global timeout");
  end

endmodule
